// File: rtl/router_fifo.sv
// -----------------------------------------------------------------------------
// router_fifo
//
// Per-destination output FIFO of the 1x3 router. It sits directly downstream
// of the synchronizer: the synchronizer supplies one bit of its one-hot
// write-enable and the timeout soft reset, the FSM supplies the byte stream
// and the first-byte (lfd) flag, and the external reader drains it.
//
// Each entry stores {lfd_state, data_in}. When a header byte (lfd=1) is read,
// its length field plus one (payload + parity) loads a packet counter. The
// counter is decremented on every following byte. While that counter is zero
// and no read is taken, data_out is driven to 0 so the output bus idles clean.
//
// Optional feature macro: ROUTER_FIFO_OCCUPANCY_EN
//   Defined     -> adds output fill_level = wr_ptr - rd_ptr (0..DEPTH).
//   Not defined -> no fill_level port; behaviour otherwise identical.
//
// Ports
//   clock       in   1          rising-edge clock
//   reset       in   1          asynchronous, active-high reset
//   soft_reset  in   1          synchronous flush (timeout from synchronizer)
//   write_enb   in   1          write request
//   read_enb    in   1          read request from the output port
//   lfd_state   in   1          1 = data_in is a packet header byte
//   data_in     in   WIDTH      byte to store
//   data_out    out  WIDTH      registered read data (1-cycle latency)
//   full        out  1          occupancy == DEPTH
//   empty       out  1          occupancy == 0
//   fill_level  out  ADDR_W+1   occupancy (only with ROUTER_FIFO_OCCUPANCY_EN)
// -----------------------------------------------------------------------------
module router_fifo #(
   parameter int DEPTH  = 16,   // power of two, >= 4
   parameter int WIDTH  = 8,    // data byte width
   parameter int ADDR_W = 4     // log2(DEPTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             soft_reset,
   input  logic             write_enb,
   input  logic             read_enb,
   input  logic             lfd_state,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             full,
`ifdef ROUTER_FIFO_OCCUPANCY_EN
   output logic             empty,
   output logic [ADDR_W:0]  fill_level
`else
   output logic             empty
`endif
);

   // Pointers carry one extra wrap bit so full and empty are distinguishable
   // without a separate occupancy counter.
   typedef logic [ADDR_W:0] ptr_t;

   typedef struct packed {
      logic             lfd;
      logic [WIDTH-1:0] data;
   } entry_t;

   localparam int CNT_W = 7;

   entry_t           mem [DEPTH];
   entry_t           rd_entry;

   ptr_t             wr_ptr, wr_ptr_nxt;
   ptr_t             rd_ptr, rd_ptr_nxt;
   logic [CNT_W-1:0] pkt_cnt, pkt_cnt_nxt;
   logic [WIDTH-1:0] data_out_nxt;

   logic             wr_accept;
   logic             rd_accept;

   // --------------------------------------------------------------------------
   // Flags: purely combinational from the registered pointers, so both reflect
   // the state sampled before the edge when read and write collide.
   // --------------------------------------------------------------------------
   assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                  (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
   assign empty = (wr_ptr == rd_ptr);

   // Soft reset wins over both sides; a full FIFO drops writes and an empty
   // one ignores reads.
   assign wr_accept = write_enb && !full  && !soft_reset;
   assign rd_accept = read_enb  && !empty && !soft_reset;

   assign rd_entry  = mem[rd_ptr[ADDR_W-1:0]];

`ifdef ROUTER_FIFO_OCCUPANCY_EN
   // Modulo-2*DEPTH difference yields 0..DEPTH because the wrap bit is kept.
   assign fill_level = wr_ptr - rd_ptr;
`endif

   // --------------------------------------------------------------------------
   // Storage.
   // NOTE: the array is deliberately left out of the reset; its contents are
   // never observable before being written, and resetting it would turn a
   // simple RAM into a bank of resettable flops.
   // --------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (wr_accept) begin
         mem[wr_ptr[ADDR_W-1:0]] <= '{lfd: lfd_state, data: data_in};
      end
   end

   // --------------------------------------------------------------------------
   // Next-state logic for pointers, packet counter and read data.
   // NOTE: every output of this block is given a hold value first; a path that
   // leaves a variable unassigned would otherwise infer a latch.
   // --------------------------------------------------------------------------
   always_comb begin
      wr_ptr_nxt   = wr_ptr;
      rd_ptr_nxt   = rd_ptr;
      pkt_cnt_nxt  = pkt_cnt;
      data_out_nxt = data_out;

      if (soft_reset) begin
         // Flush: any partially delivered packet is discarded.
         wr_ptr_nxt   = '0;
         rd_ptr_nxt   = '0;
         pkt_cnt_nxt  = '0;
         data_out_nxt = '0;
      end else begin
         if (wr_accept) begin
            wr_ptr_nxt = wr_ptr + ptr_t'(1);
         end

         if (rd_accept) begin
            rd_ptr_nxt   = rd_ptr + ptr_t'(1);
            data_out_nxt = rd_entry.data;
            if (rd_entry.lfd) begin
               // Header length field counts payload bytes; +1 covers parity.
               pkt_cnt_nxt = CNT_W'(rd_entry.data[WIDTH-1:2]) + CNT_W'(1);
            end else if (pkt_cnt != '0) begin
               pkt_cnt_nxt = pkt_cnt - CNT_W'(1);
            end
         end else if (pkt_cnt == '0) begin
            // Between packets the output bus idles at zero.
            data_out_nxt = '0;
         end
      end
   end

   // --------------------------------------------------------------------------
   // State registers.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values computed above, independent of block order.
   // --------------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         pkt_cnt  <= '0;
         data_out <= '0;
      end else begin
         wr_ptr   <= wr_ptr_nxt;
         rd_ptr   <= rd_ptr_nxt;
         pkt_cnt  <= pkt_cnt_nxt;
         data_out <= data_out_nxt;
      end
   end

endmodule
